param_interleaver: RTL and testbench
====================================

PARAM_INTERLEAVER -- requirements
Module: param_interleaver

Interface
REQ-001 SHALL have parameter ROWS, default 4, matrix row count (>=2).
REQ-002 SHALL have parameter COLS, default 4, matrix column count (>=2); N = ROWS*COLS samples per frame.
REQ-003 SHALL have parameter WIDTH, default 1, sample width in bits.
REQ-004 SHALL have parameter MODE, default 0; 0 = interleave, 1 = deinterleave.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  input sample present.
REQ-008 SHALL have port in_sof  input  1  input sample is first of a frame.
REQ-009 SHALL have port in_data  input  WIDTH  input sample.
REQ-010 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-012 SHALL have port out_sof  output  1  out_data is first sample of a frame.
REQ-013 SHALL have port out_data  output  WIDTH  output sample.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-015 SHALL have port sync_err  output  1  one-cycle pulse on frame resync.

Function
REQ-016 SHALL accept a sample on any edge with in_valid=1 and in_ready=1, and transfer output on any edge with out_valid=1 and out_ready=1.
REQ-017 SHALL use two ping-pong banks of N words; each bank in state EMPTY, FILLING, FULL or DRAINING.
REQ-018 SHALL write the k-th accepted sample of a frame to bank address k (k = 0..N-1) in both modes.
REQ-019 SHALL, in MODE 0, read output sample j from address (j mod ROWS)*COLS + j/ROWS.
REQ-020 SHALL, in MODE 1, read output sample i from address (i mod COLS)*ROWS + i/COLS, so MODE 1 exactly inverts MODE 0 for equal ROWS/COLS.
REQ-021 SHALL drive in_ready=1 while the write bank is EMPTY or FILLING, else 0.
REQ-022 SHALL mark a bank FULL on the edge accepting sample N-1, switch writing to the other bank, and wrap the write counter to 0.
REQ-023 SHALL load the output register whenever out_valid=0 or out_ready=1 and a FULL/DRAINING bank has samples left; out_data/out_sof SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL set a bank EMPTY on the edge its last sample loads into the output register; the writer may use it next cycle.
REQ-025 SHALL, with continuous input and out_ready=1, assert first out_valid in cycle N+1 after the first accept (cycle 0) and sustain one sample per cycle thereafter.
REQ-026 SHALL assert out_sof with output sample 0 of each frame only.
REQ-027 SHALL, when in_sof=1 is accepted with write counter nonzero, discard the partial frame, store the sample at address 0, and pulse sync_err for one cycle.
REQ-028 SHALL accept samples at counter 0 without in_sof (free-running framing).
REQ-029 SHALL handle a write-bank completion and a read-bank completion on the same edge, the two events affecting different banks independently.
REQ-030 SHALL compute addresses with $clog2(N)-bit counters; no counter exceeds N-1.

Reset
REQ-031 SHALL, while rst=0 at an edge, set both banks EMPTY, counters to 0, bank selectors to bank 0, out_valid=0, out_sof=0, out_data=0, sync_err=0.
REQ-032 SHALL drop any partial or buffered frame on reset mid-operation; bank memory contents need no reset.

Structure
REQ-033 SHALL take mode constants, bank-state encoding and the two address-mapping functions from shared package interleaver_pkg.
REQ-034 SHALL instantiate sub-module interleaver_bank (N x WIDTH, one write port, one read port) twice.

Verification
REQ-035 SHALL verify: MODE 0, 4x4, WIDTH=8, in_data 0..15 continuous -> out 0,4,8,12,1,5,9,13,2,...,15, out_sof with 0, first out_valid cycle 17.
REQ-036 SHALL verify: MODE 0 then MODE 1 chained, 3x5, 4 frames random data -> output equals input, one sample/cycle.
REQ-037 SHALL verify: out_ready=0 for 40 cycles, 4x4 -> in_ready falls after 32 accepts, no sample lost or duplicated.
REQ-038 SHALL verify: in_sof at write count 6 -> sync_err pulse, 6 samples discarded, next frame output correct.
REQ-039 SHALL verify: rst=0 mid-drain -> next cycle out_valid=0, in_ready=1, following frame correct.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared definitions for the ping-pong block interleaver: mode constants,
// bank-state encoding and the read-address mappings for both directions.
package interleaver_pkg;

  localparam int MODE_IL  = 0;
  localparam int MODE_DIL = 1;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Row-major write, column-major read.
  function automatic int il_addr(input int j, input int rows, input int cols);
    return (j % rows) * cols + j / rows;
  endfunction

  // Exact inverse of il_addr for the same rows/cols.
  function automatic int dil_addr(input int i, input int rows, input int cols);
    return (i % cols) * rows + i / cols;
  endfunction

endpackage

// File: rtl/interleaver_bank.sv
// One frame buffer: a single write port and an asynchronous read port, so the
// output register can capture the addressed word on the same edge it is selected.
module interleaver_bank #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_interleaver.sv
// Row/column block interleaver (MODE 0) or deinterleaver (MODE 1) with two
// ping-pong banks: one bank fills while the other drains into a registered output.
module param_interleaver import interleaver_pkg::*; #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 1,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sync_err
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  bank_state_t           st [2];
  logic                  wr_sel, rd_sel;
  logic [AW-1:0]         wr_cnt, rd_cnt, waddr, raddr;
  logic [1:0][WIDTH-1:0] rdata;
  logic                  accept, resync, rd_avail, load;

  assign in_ready = (st[wr_sel] == BANK_EMPTY) || (st[wr_sel] == BANK_FILLING);
  assign accept   = in_valid && in_ready;
  assign resync   = accept && in_sof && (wr_cnt != '0);
  assign waddr    = resync ? '0 : wr_cnt;
  assign rd_avail = (st[rd_sel] == BANK_FULL) || (st[rd_sel] == BANK_DRAINING);
  assign load     = rd_avail && (!out_valid || out_ready);

  if (MODE == MODE_DIL) begin : g_dil
    assign raddr = AW'(dil_addr(32'(rd_cnt), ROWS, COLS));
  end else begin : g_il
    assign raddr = AW'(il_addr(32'(rd_cnt), ROWS, COLS));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    interleaver_bank #(.DEPTH(N), .WIDTH(WIDTH), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (accept && (wr_sel == 1'(b))),
      .waddr (waddr),
      .wdata (in_data),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  // The writer only touches EMPTY/FILLING banks and the reader only FULL/DRAINING
  // ones, so both state updates below always target different banks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st[0]     <= BANK_EMPTY;
      st[1]     <= BANK_EMPTY;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= resync;
      if (accept) begin
        if (resync) begin
          wr_cnt     <= AW'(1);
          st[wr_sel] <= BANK_FILLING;
        end else if (wr_cnt == LAST) begin
          wr_cnt     <= '0;
          st[wr_sel] <= BANK_FULL;
          wr_sel     <= ~wr_sel;
        end else begin
          wr_cnt     <= wr_cnt + 1'b1;
          st[wr_sel] <= BANK_FILLING;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_sof   <= (rd_cnt == '0);
        out_data  <= rdata[rd_sel];
        if (rd_cnt == LAST) begin
          rd_cnt     <= '0;
          st[rd_sel] <= BANK_EMPTY;
          rd_sel     <= ~rd_sel;
        end else begin
          rd_cnt     <= rd_cnt + 1'b1;
          st[rd_sel] <= BANK_DRAINING;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_interleaver.sv
// Directed bench: 4x4 interleaver standalone plus a 3x5 interleaver/deinterleaver chain.
module tb_param_interleaver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Column-major read order of a 4x4 frame written row-major.
  int tab [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  logic       a_iv, a_isof, a_ir, a_ov, a_osof, a_or, a_se;
  logic [7:0] a_id, a_od;

  logic       b_iv, b_isof, b_ir, m_v, m_sof, m_r, m_se, c_ov, c_osof, c_or, c_se;
  logic [7:0] b_id, m_d, c_od;

  param_interleaver #(.ROWS(4), .COLS(4), .WIDTH(8), .MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_sof(a_isof), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_sof(a_osof), .out_data(a_od), .out_ready(a_or), .sync_err(a_se)
  );

  param_interleaver #(.ROWS(3), .COLS(5), .WIDTH(8), .MODE(0)) u_il (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_sof(b_isof), .in_data(b_id), .in_ready(b_ir),
    .out_valid(m_v), .out_sof(m_sof), .out_data(m_d), .out_ready(m_r), .sync_err(m_se)
  );

  param_interleaver #(.ROWS(3), .COLS(5), .WIDTH(8), .MODE(1)) u_dil (
    .clk(clk), .rst(rst), .in_valid(m_v), .in_sof(m_sof), .in_data(m_d), .in_ready(m_r),
    .out_valid(c_ov), .out_sof(c_osof), .out_data(c_od), .out_ready(c_or), .sync_err(c_se)
  );

  task automatic test_reset;
    rst = 1'b0;
    a_iv = 0; a_isof = 0; a_id = '0; a_or = 0;
    b_iv = 0; b_isof = 0; b_id = '0; c_or = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", a_ov); end
    n_tests++; if (a_osof !== 1'b0) begin n_fail++; $display("FAIL reset_out_sof: got %b exp 0", a_osof); end
    n_tests++; if (a_od !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h exp 00", a_od); end
    n_tests++; if (a_se !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b exp 0", a_se); end
    n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", a_ir); end
    n_tests++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL reset_chain_valid: got %b exp 0", c_ov); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int first = -1;
    int got = 0;
    logic [7:0] exp;
    a_or = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (a_ov) begin
        if (first < 0) first = c;
        exp = (got < 16) ? 8'(tab[got]) : 8'hxx;
        n_tests++; if (a_od !== exp) begin n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", got, a_od, exp); end
        n_tests++; if (a_osof !== (got == 0)) begin n_fail++; $display("FAIL basic_sof[%0d]: got %b exp %b", got, a_osof, got == 0); end
        got++;
      end
      if (c < 16) begin
        n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready[%0d]: got %b exp 1", c, a_ir); end
      end
      a_iv = (c < 16); a_isof = (c == 0); a_id = 8'(c);
      @(negedge clk);
    end
    a_iv = 0; a_isof = 0;
    n_tests++; if (first !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d exp 17", first); end
    n_tests++; if (got !== 16) begin n_fail++; $display("FAIL basic_count: got %0d exp 16", got); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int got = 0;
    logic [7:0] exp;
    a_or = 1'b0;
    for (int c = 0; c < 40; c++) begin
      a_iv = 1'b1; a_isof = (acc == 0); a_id = 8'(acc);
      if (a_ir) acc++;
      @(negedge clk);
    end
    n_tests++; if (acc !== 32) begin n_fail++; $display("FAIL bp_accepts: got %0d exp 32", acc); end
    n_tests++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", a_ir); end
    n_tests++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b exp 1", a_ov); end
    n_tests++; if (a_od !== 8'h00) begin n_fail++; $display("FAIL bp_hold_data: got %h exp 00", a_od); end
    n_tests++; if (a_osof !== 1'b1) begin n_fail++; $display("FAIL bp_hold_sof: got %b exp 1", a_osof); end
    a_iv = 1'b0; a_isof = 1'b0; a_or = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (a_ov) begin
        exp = (got < 32) ? 8'((got / 16) * 16 + tab[got % 16]) : 8'hxx;
        n_tests++; if (a_od !== exp) begin n_fail++; $display("FAIL bp_data[%0d]: got %h exp %h", got, a_od, exp); end
        got++;
      end
      @(negedge clk);
    end
    n_tests++; if (got !== 32) begin n_fail++; $display("FAIL bp_count: got %0d exp 32", got); end
  endtask

  task automatic test_sync;
    int got = 0;
    int se_cnt = 0;
    int se_cyc = -1;
    logic [7:0] exp;
    a_or = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (a_se) begin se_cnt++; se_cyc = c; end
      if (a_ov) begin
        exp = (got < 16) ? 8'(tab[got]) : 8'hxx;
        n_tests++; if (a_od !== exp) begin n_fail++; $display("FAIL sync_data[%0d]: got %h exp %h", got, a_od, exp); end
        n_tests++; if (a_osof !== (got == 0)) begin n_fail++; $display("FAIL sync_sof[%0d]: got %b exp %b", got, a_osof, got == 0); end
        got++;
      end
      if (c < 6) begin
        a_iv = 1; a_isof = (c == 0); a_id = 8'(200 + c);
      end else if (c < 22) begin
        a_iv = 1; a_isof = (c == 6); a_id = 8'(c - 6);
      end else begin
        a_iv = 0; a_isof = 0;
      end
      @(negedge clk);
    end
    a_iv = 0; a_isof = 0;
    n_tests++; if (se_cnt !== 1) begin n_fail++; $display("FAIL sync_err_count: got %0d exp 1", se_cnt); end
    n_tests++; if (se_cyc !== 7) begin n_fail++; $display("FAIL sync_err_cycle: got %0d exp 7", se_cyc); end
    n_tests++; if (got !== 16) begin n_fail++; $display("FAIL sync_count: got %0d exp 16", got); end
  endtask

  task automatic test_reset_mid;
    int got = 0;
    logic [7:0] exp;
    a_or = 1'b1;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (a_ov) begin
        exp = 8'(50 + tab[got]);
        n_tests++; if (a_od !== exp) begin n_fail++; $display("FAIL rmid_pre_data[%0d]: got %h exp %h", got, a_od, exp); end
        got++;
      end
      a_iv = (c < 16); a_isof = (c == 0); a_id = 8'(50 + c);
      @(negedge clk);
    end
    n_tests++; if (got !== 5) begin n_fail++; $display("FAIL rmid_drain_start: got %0d exp 5", got); end
    a_iv = 0; a_isof = 0; rst = 1'b0;
    @(negedge clk);
    n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b exp 0", a_ov); end
    n_tests++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b exp 1", a_ir); end
    rst = 1'b1;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (a_ov) begin
        exp = (got < 16) ? 8'(tab[got]) : 8'hxx;
        n_tests++; if (a_od !== exp) begin n_fail++; $display("FAIL rmid_post_data[%0d]: got %h exp %h", got, a_od, exp); end
        n_tests++; if (a_osof !== (got == 0)) begin n_fail++; $display("FAIL rmid_post_sof[%0d]: got %b exp %b", got, a_osof, got == 0); end
        got++;
      end
      a_iv = (c < 16); a_isof = (c == 0); a_id = 8'(c);
      @(negedge clk);
    end
    a_iv = 0; a_isof = 0;
    n_tests++; if (got !== 16) begin n_fail++; $display("FAIL rmid_post_count: got %0d exp 16", got); end
  endtask

  task automatic test_chain;
    logic [7:0] src [60];
    int si = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    int se_cnt = 0;
    for (int i = 0; i < 60; i++) src[i] = 8'($urandom);
    c_or = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (m_se || c_se) se_cnt++;
      if (c_ov) begin
        if (first < 0) first = c;
        last = c;
        if (got < 60) begin
          n_tests++; if (c_od !== src[got]) begin n_fail++; $display("FAIL chain_data[%0d]: got %h exp %h", got, c_od, src[got]); end
        end
        n_tests++; if (c_osof !== (got % 15 == 0)) begin n_fail++; $display("FAIL chain_sof[%0d]: got %b exp %b", got, c_osof, got % 15 == 0); end
        got++;
      end
      b_iv = (si < 60); b_isof = (si % 15 == 0); b_id = (si < 60) ? src[si] : 8'h00;
      if (b_iv && b_ir) si++;
      @(negedge clk);
    end
    b_iv = 0; b_isof = 0;
    n_tests++; if (si !== 60) begin n_fail++; $display("FAIL chain_accepts: got %0d exp 60", si); end
    n_tests++; if (got !== 60) begin n_fail++; $display("FAIL chain_count: got %0d exp 60", got); end
    n_tests++; if (last - first !== 59) begin n_fail++; $display("FAIL chain_rate: got span %0d exp 59", last - first); end
    n_tests++; if (se_cnt !== 0) begin n_fail++; $display("FAIL chain_sync_err: got %0d exp 0", se_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sync();
    test_reset_mid();
    test_chain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
